cart_upload: RTL and testbench

- Read-side counterpart of the cartridge download path.
- Serves HPS upload (readback) requests by fetching bytes from cartridge RAM and returning them on the ioctl upload interface, stalling the HPS with ioctl_wait.
- Shares the cart RAM read port with the core through a request/grant arbiter.
- Bounds reads by the image-size mask built during download and keeps a running checksum of the delivered bytes.

---
 rtl/vectrex_io_pkg.sv | 14 +
 rtl/upload_csum.sv | 30 +++
 rtl/cart_upload.sv | 154 +++++++++++++++
 tb/tb_cart_upload.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vectrex_io_pkg.sv
// Shared types and constants for the cartridge HPS I/O paths (download/upload).
package vectrex_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;
    localparam int         IOCTL_AW  = 25;

endpackage

// File: rtl/upload_csum.sv
// 16-bit running byte sum with synchronous clear; clear wins over add.
module upload_csum (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        add_en,
    input  logic [7:0]  din,
    output logic [15:0] sum
);

    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr)
            sum_d = 16'h0000;
        else if (add_en)
            sum_d = sum_q + {8'h00, din};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sum_q <= 16'h0000;
        else
            sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/cart_upload.sv
// HPS upload (readback) of cartridge RAM: range check, arbitrated RAM read,
// fixed-latency capture, stall to HPS and running checksum of delivered bytes.
module cart_upload
    import vectrex_io_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ioctl_upload,
    input  logic                ioctl_rd,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    output logic [7:0]          ioctl_din,
    output logic                ioctl_wait,
    input  logic [ADDR_W-1:0]   cart_mask,
    output logic                ram_rd,
    input  logic                ram_gnt,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [7:0]          ram_dout,
    output logic [15:0]         checksum,
    output logic                upload_done,
    output logic                overrun
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wait_q, wait_d;
    logic                ram_rd_q, ram_rd_d;
    logic                ovr_q, ovr_d;
    logic                upl_q, upl_d;
    logic                done_q, done_d;

    logic                rise, fall, rd_ok, out_of_range;
    logic                csum_clr, csum_add;

    assign rise  = ioctl_upload & ~upl_q;
    assign fall  = ~ioctl_upload & upl_q;
    assign rd_ok = ioctl_upload & ioctl_rd;

    // Anything above the RAM window, or any bit outside the image mask, misses.
    assign out_of_range = (ioctl_addr[IOCTL_AW-1:ADDR_W] != '0) ||
                          ((ioctl_addr[ADDR_W-1:0] & ~cart_mask) != '0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        ram_rd_d = ram_rd_q;
        ovr_d    = ovr_q;
        upl_d    = ioctl_upload;
        done_d   = fall;
        csum_clr = rise;
        csum_add = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_ok) begin
                    addr_d = ioctl_addr[ADDR_W-1:0];
                    if (out_of_range) begin
                        data_d  = FILL_BYTE;
                        state_d = DONE;
                    end else begin
                        ram_rd_d = 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (ram_gnt) begin
                    ram_rd_d = 1'b0;
                    cnt_d    = LAT_INIT;
                    state_d  = LAT;
                end
            end
            LAT: begin
                if (cnt_q == '0) begin
                    data_d  = ram_dout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                csum_add = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Session end kills a read still waiting on RAM; a byte already in
        // DONE is delivered and counted as usual.
        if (fall && (state_q == REQ || state_q == LAT)) begin
            state_d  = IDLE;
            ram_rd_d = 1'b0;
            data_d   = data_q;
        end

        if (rd_ok && state_q != IDLE)
            ovr_d = 1'b1;
        if (rise)
            ovr_d = 1'b0;
    end

    // Stall tracks the next state so it rises the cycle after the strobe.
    assign wait_d = (state_d != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= 8'h00;
            cnt_q    <= '0;
            wait_q   <= 1'b0;
            ram_rd_q <= 1'b0;
            ovr_q    <= 1'b0;
            upl_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            ram_rd_q <= ram_rd_d;
            ovr_q    <= ovr_d;
            upl_q    <= upl_d;
            done_q   <= done_d;
        end
    end

    upload_csum u_csum (
        .clock  (clock),
        .reset  (reset),
        .clr    (csum_clr),
        .add_en (csum_add),
        .din    (data_q),
        .sum    (checksum)
    );

    assign ioctl_din   = data_q;
    assign ioctl_wait  = wait_q;
    assign ram_rd      = ram_rd_q;
    assign ram_addr    = addr_q;
    assign upload_done = done_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_cart_upload.sv
// Randomized self-checking bench for cart_upload against a per-read reference model.
module tb_cart_upload;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        ioctl_upload, ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [14:0] cart_mask;
    logic        ram_rd, ram_gnt;
    logic [14:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [15:0] checksum;
    logic        upload_done, overrun;

    cart_upload #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .cart_mask    (cart_mask),
        .ram_rd       (ram_rd),
        .ram_gnt      (ram_gnt),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .checksum     (checksum),
        .upload_done  (upload_done),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    // RAM model: data of a granted address appears RD_LAT cycles after the
    // grant cycle; garbage otherwise, so wrong capture timing is visible.
    logic [7:0] mem [0:32767];
    logic [7:0] dly [0:3];
    always @(posedge clock) begin
        dly[0] <= (ram_rd && ram_gnt) ? mem[ram_addr] : 8'($urandom);
        for (int k = 1; k < 4; k++) dly[k] <= dly[k-1];
    end
    assign ram_dout = dly[RD_LAT-1];

    int n_cmp = 0, n_err = 0;
    int csum_m;
    bit ovr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic sess_start;
        ioctl_upload = 1'b1;
        tick();
        csum_m = 0;
        ovr_m  = 1'b0;
        chk("start_csum", {16'h0, checksum}, 0);
        chk("start_ovr", {31'h0, overrun}, 0);
    endtask

    task automatic sess_end;
        ioctl_upload = 1'b0;
        tick();
        chk("done_pulse", {31'h0, upload_done}, 1);
        chk("end_csum", {16'h0, checksum}, csum_m);
        tick();
        chk("done_1cyc", {31'h0, upload_done}, 0);
        chk("end_csum_hold", {16'h0, checksum}, csum_m);
    endtask

    // One HPS read: grant withheld for gd REQ cycles; dbl fires a second
    // strobe while stalled.
    task automatic rd_byte(input logic [24:0] a, input int gd, input bit dbl);
        bit         inr;
        logic [7:0] exp_b, last_din;
        int         wcyc, rcyc, exp_w;
        bit         addr_ok;
        inr     = (a[24:15] == 10'h0) && ((a[14:0] & ~cart_mask) == 15'h0);
        exp_b   = inr ? mem[a[14:0]] : 8'hFF;
        exp_w   = inr ? (RD_LAT + 2 + gd) : 1;
        wcyc    = 0;
        rcyc    = 0;
        addr_ok = 1'b1;
        last_din = 8'h00;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        ram_gnt    = 1'($urandom);
        tick();
        ioctl_rd = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (!ioctl_wait) break;
            wcyc++;
            last_din = ioctl_din;
            ioctl_rd = (dbl && wcyc == 1);
            ioctl_addr = 25'($urandom);
            if (ram_rd) begin
                if (ram_addr !== a[14:0]) addr_ok = 1'b0;
                ram_gnt = (rcyc == gd);
                rcyc++;
            end else begin
                ram_gnt = 1'($urandom);
            end
            tick();
        end
        ioctl_rd = 1'b0;
        csum_m = (csum_m + exp_b) & 16'hFFFF;
        ovr_m  = ovr_m | dbl;
        chk("wait_cycles", wcyc, exp_w);
        chk("din_done", {24'h0, last_din}, {24'h0, exp_b});
        chk("din_hold", {24'h0, ioctl_din}, {24'h0, exp_b});
        chk("ram_rd_cycles", rcyc, inr ? gd + 1 : 0);
        chk("ram_addr", {31'h0, addr_ok}, 1);
        chk("csum", {16'h0, checksum}, csum_m);
        chk("ovr", {31'h0, overrun}, {31'h0, ovr_m});
    endtask

    initial begin
        logic [24:0] a;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[15'h0123] = 8'hA5;
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
        cart_mask = 15'h1FFF; ram_gnt = 1'b0;
        csum_m = 0; ovr_m = 1'b0;
        tick(); tick();
        chk("reset_outs", {ioctl_din, ioctl_wait, ram_rd, ram_addr, upload_done, overrun},
            32'h0);
        chk("reset_csum", {16'h0, checksum}, 0);
        reset = 1'b0;
        tick();

        // Basic in-range read, immediate grant
        sess_start();
        rd_byte(25'h0123, 0, 0);
        // Out-of-range reads: masked bit and upper window bit
        cart_mask = 15'h0FFF;
        rd_byte(25'h1000, 0, 0);
        rd_byte(25'h8000, 0, 0);
        // Late grant
        cart_mask = 15'h1FFF;
        rd_byte(25'h0123, 5, 0);
        // Strobe while busy
        rd_byte(25'h0040, 0, 1);
        sess_end();
        // Strobe with no session: ignored, no flag change
        ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("rd_no_sess_wait", {31'h0, ioctl_wait}, 0);
        chk("rd_no_sess_ovr", {31'h0, overrun}, {31'h0, ovr_m});
        tick();

        // New session clears overrun; checksum wrap over many 0xFF bytes
        cart_mask = 15'h0FFF;
        sess_start();
        for (int i = 0; i < 258; i++)
            rd_byte((i % 2 == 0) ? 25'h1000 : 25'h8000, 0, 0);
        sess_end();

        // Abort during LAT: nothing added
        cart_mask = 15'h1FFF;
        sess_start();
        rd_byte(25'h0077, 1, 0);
        ioctl_rd = 1'b1; ioctl_addr = 25'h0123; ram_gnt = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        ioctl_upload = 1'b0;
        tick();
        chk("abort_wait", {31'h0, ioctl_wait}, 0);
        chk("abort_ram_rd", {31'h0, ram_rd}, 0);
        chk("abort_done", {31'h0, upload_done}, 1);
        chk("abort_csum", {16'h0, checksum}, csum_m);
        tick(); tick();
        chk("abort_csum_hold", {16'h0, checksum}, csum_m);

        // Async reset during REQ
        sess_start();
        ioctl_rd = 1'b1; ioctl_addr = 25'h0123; ram_gnt = 1'b0;
        tick();
        ioctl_rd = 1'b0;
        tick();
        chk("req_ram_rd", {31'h0, ram_rd}, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outs",
            {ioctl_din, ioctl_wait, ram_rd, ram_addr, upload_done, overrun}, 32'h0);
        chk("async_rst_csum", {16'h0, checksum}, 0);
        tick();
        reset = 1'b0;
        csum_m = 0; ovr_m = 1'b0;
        tick();
        chk("post_rst_done", {31'h0, upload_done}, 0);
        rd_byte(25'h0123, 0, 0);
        sess_end();

        // Randomized sessions
        for (int s = 0; s < 4; s++) begin
            cart_mask = 15'((32'd1 << $urandom_range(8, 15)) - 1);
            sess_start();
            for (int r = 0; r < 40; r++) begin
                int k;
                k = $urandom_range(0, 9);
                if (k < 6)      a = {10'h0, 15'($urandom) & cart_mask};
                else if (k < 8) a = {10'h0, 15'($urandom)};
                else            a = 25'($urandom);
                rd_byte(a, $urandom_range(0, 5), ($urandom_range(0, 9) == 0));
            end
            sess_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
